// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and flag-position definitions for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_LSL   = 4'b0011;
  localparam logic [3:0] ALU_LSR   = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_SLT   = 4'b1000;
  localparam logic [3:0] ALU_MUL   = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // bit positions inside the registered flag vector
  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_C = 2;
  localparam int FLG_V = 3;
  localparam int NFLG  = 4;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle evaluator for every opcode except MUL, which seq_alu iterates.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] dif;

  assign sum = {1'b0, a} + {1'b0, b};
  // top bit of the extended difference is the borrow
  assign dif = {1'b0, a} - {1'b0, b};

  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    illegal  = 1'b0;
    case (op)
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_ADD: begin
        result   = sum[WIDTH-1:0];
        carry    = sum[WIDTH];
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_LSL:   result = a << b[SHW-1:0];
      ALU_LSR:   result = a >> b[SHW-1:0];
      ALU_SUB: begin
        result   = dif[WIDTH-1:0];
        carry    = ~dif[WIDTH];
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_PASSB: result = b;
      ALU_SLT:   result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_MUL:   result = '0;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle ops via alu_comb, MUL via a WIDTH-cycle shift-add loop.
// state | meaning: IDLE accept op | MUL shift-add iterating | DONE result held until taken
module seq_alu
  import alu_pkg::*;
#(
  parameter  int WIDTH = 64,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             ResetL,
  input  logic             InValid,
  output logic             InReady,
  input  logic [3:0]       ALUCtrl,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] BusW,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow,
  output logic             Illegal
);

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, mcand_q, mplier_q, busw_q;
  logic [SHW-1:0]   cnt_q;
  logic [NFLG-1:0]  flags_q;
  logic             illegal_q;

  logic [WIDTH-1:0] c_res;
  logic             c_carry, c_ovf, c_ill;
  logic             accept, is_mul, last;
  logic [WIDTH-1:0] mul_sum, wr_res;
  logic [NFLG-1:0]  wr_flags;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .op       (ALUCtrl),
    .a        (BusA),
    .b        (BusB),
    .result   (c_res),
    .carry    (c_carry),
    .overflow (c_ovf),
    .illegal  (c_ill)
  );

  assign InReady  = ResetL && (state_q == ST_IDLE);
  assign accept   = InValid && InReady;
  assign is_mul   = (ALUCtrl == ALU_MUL);
  assign last     = (cnt_q == CNT_LAST);
  assign mul_sum  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    wr_res          = (state_q == ST_MUL) ? mul_sum : c_res;
    wr_flags        = '0;
    wr_flags[FLG_Z] = (wr_res == '0);
    wr_flags[FLG_N] = wr_res[WIDTH-1];
    if (state_q != ST_MUL) begin
      wr_flags[FLG_C] = c_carry;
      wr_flags[FLG_V] = c_ovf;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = is_mul ? ST_MUL : ST_DONE;
      ST_MUL:  if (last) state_d = ST_DONE;
      ST_DONE: if (OutReady) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!ResetL) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge CLK) begin
    if (!ResetL) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      busw_q    <= '0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept && is_mul) begin
            mcand_q  <= BusA;
            mplier_q <= BusB;
            acc_q    <= '0;
            cnt_q    <= '0;
          end else if (accept) begin
            busw_q    <= wr_res;
            flags_q   <= wr_flags;
            illegal_q <= c_ill;
          end
        end
        ST_MUL: begin
          acc_q    <= mul_sum;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + SHW'(1);
          if (last) begin
            busw_q    <= wr_res;
            flags_q   <= wr_flags;
            illegal_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign OutValid = (state_q == ST_DONE);
  assign BusW     = busw_q;
  assign Zero     = flags_q[FLG_Z];
  assign Negative = flags_q[FLG_N];
  assign Carry    = flags_q[FLG_C];
  assign Overflow = flags_q[FLG_V];
  assign Illegal  = illegal_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed scoreboard bench for seq_alu at WIDTH=64 and WIDTH=8.
module tb_seq_alu;
  import alu_pkg::*;

  typedef struct packed {
    logic [63:0] w;
    logic [4:0]  f;   // {illegal, overflow, carry, negative, zero}
  } exp_t;

  exp_t sb[$];
  int   vecs = 0;
  int   errs = 0;

  logic        CLK = 1'b0;
  logic        rstl;
  logic        iv64, ir64, ov64, or64, z64, n64, c64, v64, il64;
  logic [3:0]  op64;
  logic [63:0] a64, b64, w64;
  logic        iv8, ir8, ov8, or8, z8, n8, c8, v8, il8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8, w8;

  always #5 CLK = ~CLK;

  seq_alu #(.WIDTH(64)) dut64 (
    .CLK(CLK), .ResetL(rstl), .InValid(iv64), .InReady(ir64), .ALUCtrl(op64),
    .BusA(a64), .BusB(b64), .OutValid(ov64), .OutReady(or64), .BusW(w64),
    .Zero(z64), .Negative(n64), .Carry(c64), .Overflow(v64), .Illegal(il64)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .CLK(CLK), .ResetL(rstl), .InValid(iv8), .InReady(ir8), .ALUCtrl(op8),
    .BusA(a8), .BusB(b8), .OutValid(ov8), .OutReady(or8), .BusW(w8),
    .Zero(z8), .Negative(n8), .Carry(c8), .Overflow(v8), .Illegal(il8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input bit nar, input logic [3:0] op, input logic [63:0] a,
                      input logic [63:0] b, input bit push, input logic [63:0] ew,
                      input logic [4:0] ef);
    exp_t e;
    @(negedge CLK);
    check("in_ready_before_send", nar ? ir8 : ir64, 64'd1);
    if (nar) begin
      iv8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      iv64 = 1'b1; op64 = op; a64 = a; b64 = b;
    end
    if (push) begin
      e.w = ew;
      e.f = ef;
      sb.push_back(e);
    end
    @(posedge CLK);
    #1;
    iv8  = 1'b0;
    iv64 = 1'b0;
  endtask

  // Called #1 after the accept edge; that point is cycle 1 after accept.
  task automatic recv(input bit nar, input int exp_lat, input string tag, input bit release_out);
    int          lat;
    exp_t        e;
    logic [63:0] ow;
    logic [4:0]  of;
    lat = 1;
    while (!(nar ? ov8 : ov64) && lat < 300) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    e = '0;
    if (sb.size() != 0) e = sb.pop_front();
    ow = nar ? {56'd0, w8} : w64;
    of = nar ? {il8, v8, c8, n8, z8} : {il64, v64, c64, n64, z64};
    check({tag, "_busw"}, ow, e.w);
    check({tag, "_flags"}, 64'(of), 64'(e.f));
    if (release_out) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    rstl = 1'b0;
    iv64 = 1'b0; op64 = '0; a64 = '0; b64 = '0; or64 = 1'b1;
    iv8  = 1'b0; op8  = '0; a8  = '0; b8  = '0; or8  = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_out_valid", 64'(ov64), 64'd0);
    check("rst_busw", w64, 64'd0);
    check("rst_in_ready_low", 64'(ir64), 64'd0);
    @(negedge CLK);
    rstl = 1'b1;

    send(0, ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1, 64'd0, 5'b00101);
    recv(0, 1, "add_wrap", 1);
    send(0, ALU_SUB, 64'h8000_0000_0000_0000, 64'd1, 1, 64'h7FFF_FFFF_FFFF_FFFF, 5'b01100);
    recv(0, 1, "sub_ovf", 1);
    send(0, ALU_SUB, 64'd1, 64'd2, 1, 64'hFFFF_FFFF_FFFF_FFFF, 5'b00010);
    recv(0, 1, "sub_borrow", 1);

    send(1, ALU_MUL, 64'h0F, 64'h11, 1, 64'hFF, 5'b00010);
    recv(1, 9, "mul8_ff", 1);
    send(1, ALU_MUL, 64'h10, 64'h10, 1, 64'h00, 5'b00001);
    recv(1, 9, "mul8_wrap", 1);
    send(0, ALU_MUL, 64'h1234, 64'h10, 1, 64'h12340, 5'b00000);
    recv(0, 65, "mul64", 1);

    // backpressure: result must hold while the consumer stalls
    or64 = 1'b0;
    send(0, ALU_ADD, 64'd3, 64'd4, 1, 64'd7, 5'b00000);
    recv(0, 1, "bp_add", 0);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", 64'(ov64), 64'd1);
      check("bp_hold_busw", w64, 64'd7);
      check("bp_in_ready_low", 64'(ir64), 64'd0);
      @(posedge CLK);
      #1;
    end
    or64 = 1'b1;
    @(posedge CLK);
    #1;
    check("bp_valid_drop", 64'(ov64), 64'd0);
    check("bp_in_ready_back", 64'(ir64), 64'd1);

    // reset ten cycles into a 64-cycle multiply
    send(0, ALU_MUL, 64'hDEAD_BEEF, 64'h1234_5678, 0, 64'd0, 5'd0);
    repeat (9) @(posedge CLK);
    #1;
    check("mid_mul_busy", 64'(ov64), 64'd0);
    @(negedge CLK);
    rstl = 1'b0;
    @(posedge CLK);
    #1;
    check("midrst_busw", w64, 64'd0);
    check("midrst_flags", 64'({il64, v64, c64, n64, z64}), 64'd0);
    check("midrst_valid", 64'(ov64), 64'd0);
    check("midrst_in_ready", 64'(ir64), 64'd0);
    @(negedge CLK);
    rstl = 1'b1;
    #1;
    check("postrst_in_ready", 64'(ir64), 64'd1);
    send(0, ALU_AND, 64'hF0, 64'h3C, 1, 64'h30, 5'b00000);
    recv(0, 1, "and_after_rst", 1);

    send(0, 4'b0101, 64'h55, 64'hAA, 1, 64'd0, 5'b10001);
    recv(0, 1, "illegal_0101", 1);
    send(0, 4'b1111, 64'h55, 64'hAA, 1, 64'd0, 5'b10001);
    recv(0, 1, "illegal_1111", 1);
    send(0, ALU_LSL, 64'd1, 64'h43, 1, 64'h8, 5'b00000);
    recv(0, 1, "lsl_masked", 1);
    send(0, ALU_LSR, 64'h8000_0000_0000_0000, 64'h3F, 1, 64'd1, 5'b00000);
    recv(0, 1, "lsr_63", 1);
    send(0, ALU_LSR, 64'hDEAD_BEEF_0000_1234, 64'h40, 1, 64'hDEAD_BEEF_0000_1234, 5'b00010);
    recv(0, 1, "lsr_zero_shift", 1);
    send(0, ALU_SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 64'd1, 5'b00000);
    recv(0, 1, "slt_neg", 1);
    send(0, ALU_SLT, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'd0, 5'b00001);
    recv(0, 1, "slt_pos", 1);
    send(0, ALU_OR, 64'hF0, 64'h0F, 1, 64'hFF, 5'b00000);
    recv(0, 1, "or", 1);
    send(0, ALU_PASSB, 64'h1, 64'h8000_0000_0000_0000, 1, 64'h8000_0000_0000_0000, 5'b00010);
    recv(0, 1, "passb", 1);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor to the processor's single-cycle 64-bit ALU.
- Adds shifts, signed set-less-than, an iterative shift-add multiplier and NZCV-style flags.
- Registered results use valid/ready handshakes on both sides, so the datapath can stall on multi-cycle ops.
- Sits between the register-read stage and write-back in the multi-cycle datapath.

Parameters:
- WIDTH, 64, datapath width in bits. Must be a power of two, 8 or greater.
- SHW, $clog2(WIDTH), shift-amount width. Derived; not overridable.

Ports:
- CLK  in  1  rising-edge clock
- ResetL  in  1  synchronous, active-low reset
- InValid  in  1  operand/opcode valid
- InReady  out  1  block can accept an operation
- ALUCtrl  in  4  opcode
- BusA  in  WIDTH  operand A
- BusB  in  WIDTH  operand B
- OutValid  out  1  result and flags valid
- OutReady  in  1  consumer takes the result
- BusW  out  WIDTH  result
- Zero  out  1  BusW == 0
- Negative  out  1  BusW[WIDTH-1]
- Carry  out  1  ADD: carry-out; SUB: no-borrow (A >= B unsigned); 0 for all other ops
- Overflow  out  1  signed overflow for ADD/SUB; 0 for all other ops
- Illegal  out  1  opcode not in the table below

Behaviour:
- Opcodes:
  - AND 0000; OR 0001; ADD 0010; LSL 0011 (A << B[SHW-1:0]); LSR 0100 (logical right shift).
  - SUB 0110; PASSB 0111; SLT 1000 (result 1 if signed A < B, else 0); MUL 1001 (low WIDTH bits of A*B).
  - Any other code: BusW = 0, Illegal = 1, single-cycle timing.
- FSM states: IDLE, MUL, DONE.
- InReady = ResetL && state == IDLE (combinational).
- Accept occurs when InValid && InReady at a rising edge.
- IDLE accepting a non-MUL op: result and flags are computed combinationally and registered; next state DONE. OutValid rises the cycle after accept (latency 1).
- IDLE accepting MUL: latch multiplicand = A, multiplier = B, acc = 0, cnt = 0; next state MUL.
- MUL state, each cycle:
  - If multiplier[0], acc += multiplicand (mod 2^WIDTH).
  - multiplicand <<= 1; multiplier >>= 1; cnt++.
  - After exactly WIDTH cycles in MUL, BusW = acc, flags registered, next state DONE. OutValid rises WIDTH+1 cycles after accept.
- DONE:
  - OutValid = 1. BusW and flags are held stable until the transfer completes.
  - OutValid && OutReady at an edge returns to IDLE. A new op may be accepted at the earliest in the following cycle (no bypass).
- Operand changes while busy are ignored, because operands are latched at accept.
- Flags for SLT and MUL: Zero and Negative derive from BusW; Carry = Overflow = 0.
- Reset (ResetL low at an edge) from any state, including mid-MUL:
  - state IDLE, BusW 0, all flags 0, OutValid 0, cnt 0.
  - Any partial product is discarded.
  - InReady is 0 while ResetL is low.
- Shifts by 0 return A unchanged. The shift amount uses only B[SHW-1:0]; upper bits of B are ignored.

Decomposition:
- Shared package alu_pkg holds:
  - the 4-bit opcode constants (ALU_AND … ALU_MUL);
  - the FSM state encoding;
  - the flag bit-order constants.
- One natural sub-module: alu_comb, the purely combinational single-cycle evaluator. Parametrised by WIDTH; outputs result, Carry, Overflow and Illegal.
- The multiplier datapath and FSM stay in seq_alu.

Test Plan:
- ADD, WIDTH=64: A=0xFFFF_FFFF_FFFF_FFFF, B=1 → one cycle later OutValid=1, BusW=0, Zero=1, Carry=1, Overflow=0.
- SUB: A=0x8000_0000_0000_0000, B=1 → BusW=0x7FFF_FFFF_FFFF_FFFF, Overflow=1, Carry=1, Negative=0.
- MUL, WIDTH=8: A=0x0F, B=0x11 → OutValid exactly 9 cycles after accept, BusW=0xFF, Negative=1. Then A=0x10, B=0x10 → BusW=0x00, Zero=1.
- Backpressure: ADD 3+4 with OutReady=0 for 5 cycles → BusW=7 held, InReady=0 throughout. OutReady=1 → OutValid drops next cycle, InReady=1.
- Reset mid-MUL (WIDTH=64, drop ResetL 10 cycles after accept) → all outputs 0 next edge, state IDLE. A following AND 0xF0 & 0x3C → 0x30.
- Opcodes 0101 and 1111 → BusW=0, Illegal=1, latency 1. LSL A=1, B=0x43 (WIDTH=64) → BusW=0x8 (shift 3). SLT A=−1, B=0 → BusW=1.
